// File: rtl/regfile_ctx.sv
// Parametrised GP/scratch register file with a shadow bank for context save/restore.
// state   | meaning
// IDLE    | no copy in progress, requests accepted
// SAVE    | copying R[k+1] into shadow[k], one register per edge
// RESTORE | copying shadow[k] into R[k+1], one register per edge
module regfile_ctx #(
   parameter int WIDTH = 16,
   parameter int NGP   = 4,
   parameter int NSCR  = 4,
   parameter int SELW  = $clog2(NGP + NSCR)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  i,
   input  logic [2:0]        fun_sel,
   input  logic [NGP-1:0]    reg_sel,
   input  logic [NSCR-1:0]   scr_sel,
   input  logic [SELW-1:0]   out_a_sel,
   input  logic [SELW-1:0]   out_b_sel,
   input  logic              save_req,
   input  logic              restore_req,
   output logic [WIDTH-1:0]  out_a,
   output logic [WIDTH-1:0]  out_b,
   output logic              busy,
   output logic              done
);

   localparam int H  = WIDTH / 2;
   localparam int KW = (NGP > 1) ? $clog2(NGP) : 1;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [KW-1:0]    LAST = KW'(NGP - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [KW-1:0]     k, k_nxt;
   logic              done_nxt;
   logic [NGP-1:0]    gp_mask_b;

   logic [WIDTH-1:0]  gp     [NGP];
   logic [WIDTH-1:0]  scr    [NSCR];
   logic [WIDTH-1:0]  shadow [NGP];

   function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      case (op)
         3'b000:  r = q - ONE;
         3'b001:  r = q + ONE;
         3'b010:  r = d;
         3'b011:  r = '0;
         3'b100:  r = {{(WIDTH-H){1'b0}}, d[H-1:0]};
         3'b101:  r = {q[WIDTH-1:H], d[H-1:0]};
         3'b110:  r = {d[H-1:0], q[H-1:0]};
         default: r = {{(WIDTH-H){d[H-1]}}, d[H-1:0]};
      endcase
      return r;
   endfunction

   assign busy = (state != IDLE);

   // GP writes are silently dropped for the whole copy so they never race the engine
   assign gp_mask_b = busy ? '1 : reg_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         k     <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            k_nxt = '0;
            if (save_req)
               state_nxt = SAVE;
            else if (restore_req)
               state_nxt = RESTORE;
         end
         SAVE, RESTORE: begin
            if (k == LAST) begin
               state_nxt = IDLE;
               k_nxt     = '0;
               done_nxt  = 1'b1;
            end else begin
               k_nxt = k + KW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            k_nxt     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NGP; j++)
            gp[j] <= '0;
      end else begin
         for (int j = 0; j < NGP; j++) begin
            if (state == RESTORE && k == KW'(j))
               gp[j] <= shadow[j];
            else if (!gp_mask_b[NGP-1-j])
               gp[j] <= apply_op(fun_sel, gp[j], i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NSCR; j++)
            scr[j] <= '0;
      end else begin
         for (int j = 0; j < NSCR; j++) begin
            if (!scr_sel[NSCR-1-j])
               scr[j] <= apply_op(fun_sel, scr[j], i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NGP; j++)
            shadow[j] <= '0;
      end else begin
         for (int j = 0; j < NGP; j++) begin
            if (state == SAVE && k == KW'(j))
               shadow[j] <= gp[j];
         end
      end
   end

   // indices past the last scratch register match nothing and read 0
   always_comb begin
      out_a = '0;
      out_b = '0;
      for (int j = 0; j < NGP; j++) begin
         if (out_a_sel == SELW'(j)) out_a = gp[j];
         if (out_b_sel == SELW'(j)) out_b = gp[j];
      end
      for (int j = 0; j < NSCR; j++) begin
         if (out_a_sel == SELW'(NGP + j)) out_a = scr[j];
         if (out_b_sel == SELW'(NGP + j)) out_b = scr[j];
      end
   end

endmodule
